dda_param_loader: RTL and testbench
===================================

// Module: dda_param_loader
// PURPOSE
//  Upstream control stage for the dda core. Receives the core's parameters over an 8-bit byte bus:
//  ic1, ic2, vK_M, vD_M, dt (posit<N,ES>) and a step count.
//  Holds the parameters stable on its outputs. On start it runs the core for a programmed
//  number of Euler steps, and it drives the core's en and rst_n pins.
//  Sits between the TT input pins and dda.
// PARAMETERS
//  N       16  posit word width; multiple of 8; sets parameter output widths
//  ES      2   posit exponent size; passed through only, no arithmetic here
//  CNT_W   16  step-counter width; the step word is CNT_W bits, CNT_W <= N
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  byte_in     in   8      load data, MSB byte of each word first
//  byte_valid  in   1      byte_in valid this cycle; 1-cycle strobe per byte
//  start       in   1      run request, level sampled per cycle
//  abort       in   1      stop run, return to IDLE
//  ic1,ic2     out  N      initial conditions to dda
//  vK_M,vD_M   out  N      k/m and d/m coefficients to dda
//  dt          out  N      time step to dda
//  dda_en      out  1      dda en
//  dda_rst_n   out  1      dda rst_n; low loads ic into the integrators
//  cfg_ok      out  1      full 6-word parameter set loaded
//  busy        out  1      state is INIT or RUN
//  done        out  1      1-cycle pulse when programmed steps complete
//  step_count  out  CNT_W  steps executed in the current or last run
// BEHAVIOUR
//  Reset values: all parameter regs, steps, byte_cnt, step_count = 0; cfg_ok = 0.
//  Reset values: dda_en = 0, dda_rst_n = 1, busy = 0, done = 0; state = IDLE.
//  Reset mid-load or mid-run aborts immediately; no done pulse.
//  Load order: word 0 ic1, 1 ic2, 2 vK_M, 3 vD_M, 4 dt, 5 steps.
//  Each word is N/8 bytes; total NB = 6*N/8 bytes (12 at N=16).
//  Byte loading is accepted only in IDLE:
//   - Each accepted byte shifts into word[byte_cnt/(N/8)] from the LSB side; byte_cnt++.
//   - The first byte of a set (byte_cnt == 0) clears cfg_ok in the same edge.
//   - Accepting byte NB-1 sets cfg_ok = 1 and byte_cnt = 0.
//   - Parameter outputs update as each byte lands; dda is frozen while dda_en = 0.
//  byte_valid in INIT or RUN: ignored, byte_cnt unchanged.
//  States:
//   IDLE: dda_en = 0, dda_rst_n = 1.
//    - start && cfg_ok && byte_cnt == 0 && !byte_valid -> INIT, and step_count <= 0.
//    - Otherwise start is ignored; byte_valid has priority over start in the same cycle.
//   INIT (exactly 1 cycle): dda_en = 1, dda_rst_n = 0, so the integrators load ic.
//    - Next state RUN; if steps == 0 go to IDLE instead, with done = 1 on that edge.
//   RUN: dda_en = 1, dda_rst_n = 1; step_count++ every cycle.
//    - When step_count == steps-1 at the edge: step_count <= steps, state -> IDLE, done = 1.
//    - Exactly `steps` RUN cycles are produced. Counter saturates; it never wraps.
//  abort (INIT or RUN): -> IDLE next edge, dda_en low, step_count frozen, no done.
//  abort has priority over completion in the same cycle. abort in IDLE has no effect.
//  All outputs are registered; dda_en and dda_rst_n are decoded from registered state, with no glitches.
//  Latency: start sampled at edge k; INIT occupies cycle k+1; first RUN is cycle k+2.
// STRUCTURE
//  dda_pkg: state encoding (IDLE/INIT/RUN); NUM_WORDS = 6; BYTES_PER_WORD = N/8.
//  dda_pkg: word index constants W_IC1..W_STEPS.
//  Sub-module dda_byte_shifter: byte counter plus word-select decode plus N-bit shift regs.
//  The FSM and step counter stay in the top module.
// TESTING
//  1 Reset: assert rst mid-RUN -> same-cycle outputs take reset values; dda_rst_n = 1, cfg_ok = 0.
//  2 Load: bytes 3C 00 | 00 00 | 38 00 | 30 00 | 20 00 | 00 05
//    -> ic1 = 3C00, ic2 = 0000, vK_M = 3800, vD_M = 3000, dt = 2000, steps = 5; cfg_ok = 1 after byte 12.
//  3 Run: start with steps = 5 -> 1 cycle dda_rst_n = 0 & en = 1, then 5 cycles en = 1.
//    -> done pulses once; step_count = 5; busy high for 6 cycles.
//  4 Edge cases:
//    - steps = 0 -> only the INIT cycle, then done.
//    - start with cfg_ok = 0 -> no state change.
//    - start with byte_valid in the same cycle -> byte taken, no run.
//  5 Abort: abort on RUN cycle 3 -> IDLE next edge, en = 0, step_count = 3, no done.
//    - Then start -> reruns from INIT.
//  6 Reload: 7 bytes then start -> ignored, cfg_ok = 0.
//    - Then 5 more bytes -> cfg_ok = 1; bytes during RUN ignored.

Source files
------------

// File: rtl/dda_pkg.sv
// rtl/dda_pkg.sv - state encoding and word layout shared by the dda parameter loader
package dda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int NUM_WORDS = 6;

  localparam int W_IC1   = 0;
  localparam int W_IC2   = 1;
  localparam int W_VKM   = 2;
  localparam int W_VDM   = 3;
  localparam int W_DT    = 4;
  localparam int W_STEPS = 5;

  function automatic int bytes_per_word(input int n);
    return n / 8;
  endfunction

endpackage

// File: rtl/dda_byte_shifter.sv
// rtl/dda_byte_shifter.sv - byte counter, word select and shift registers for the parameter set
module dda_byte_shifter
  import dda_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        accept_i,
  input  logic [7:0]                  byte_i,
  output logic [W_STEPS-1:0][N-1:0]   params_o,
  output logic [CNT_W-1:0]            steps_o,
  output logic                        cfg_ok_o,
  output logic                        set_empty_o
);

  localparam int BPW  = bytes_per_word(N);
  localparam int NB   = NUM_WORDS * BPW;
  localparam int BC_W = $clog2(NB);

  logic [BC_W-1:0]              byte_cnt_q, byte_cnt_d;
  logic                         cfg_ok_q, cfg_ok_d;
  logic [W_STEPS-1:0][N-1:0]    params_q;
  logic [CNT_W-1:0]             steps_q;
  logic [2:0]                   word_sel;
  logic                         last_byte;

  assign word_sel  = 3'(byte_cnt_q / BC_W'(BPW));
  assign last_byte = (byte_cnt_q == BC_W'(NB - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    cfg_ok_d   = cfg_ok_q;
    if (accept_i) begin
      if (byte_cnt_q == '0) cfg_ok_d = 1'b0;
      if (last_byte) begin
        byte_cnt_d = '0;
        cfg_ok_d   = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  // Only the low CNT_W bits of the step word are ever used, so only those are stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      cfg_ok_q   <= 1'b0;
      params_q   <= '0;
      steps_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      cfg_ok_q   <= cfg_ok_d;
      for (int w = 0; w < W_STEPS; w++) begin
        if (accept_i && word_sel == 3'(w))
          params_q[w] <= (params_q[w] << 8) | N'(byte_i);
      end
      if (accept_i && word_sel == 3'(W_STEPS))
        steps_q <= (steps_q << 8) | CNT_W'(byte_i);
    end
  end

  assign params_o    = params_q;
  assign steps_o     = steps_q;
  assign cfg_ok_o    = cfg_ok_q;
  assign set_empty_o = (byte_cnt_q == '0);

endmodule

// File: rtl/dda_param_loader.sv
// rtl/dda_param_loader.sv - loads dda parameters over a byte bus and sequences init/run steps
module dda_param_loader
  import dda_pkg::*;
#(
  parameter int N     = 16,
  parameter int ES    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             start,
  input  logic             abort,
  output logic [N-1:0]     ic1,
  output logic [N-1:0]     ic2,
  output logic [N-1:0]     vK_M,
  output logic [N-1:0]     vD_M,
  output logic [N-1:0]     dt,
  output logic             dda_en,
  output logic             dda_rst_n,
  output logic             cfg_ok,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_count
);

  if (N % 8 != 0 || N < 8 || CNT_W > N || ES < 0 || ES >= N) begin : g_cfg_check
    $error("dda_param_loader: unsupported N/ES/CNT_W combination");
  end

  state_e                    state_q;
  logic [CNT_W-1:0]          step_count_q;
  logic                      done_q, dda_en_q, dda_rst_n_q, busy_q;
  logic [W_STEPS-1:0][N-1:0] params;
  logic [CNT_W-1:0]          steps;
  logic                      cfg_ok_w, set_empty, accept, run_req, last_step;

  assign accept    = byte_valid && (state_q == ST_IDLE);
  assign run_req   = start && cfg_ok_w && set_empty && !byte_valid;
  assign last_step = (step_count_q == steps - 1'b1);

  dda_byte_shifter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .byte_i      (byte_in),
    .params_o    (params),
    .steps_o     (steps),
    .cfg_ok_o    (cfg_ok_w),
    .set_empty_o (set_empty)
  );

  // Pin outputs are registered alongside the state so they change only on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_count_q <= '0;
      done_q       <= 1'b0;
      dda_en_q     <= 1'b0;
      dda_rst_n_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run_req) begin
            state_q      <= ST_INIT;
            step_count_q <= '0;
            dda_en_q     <= 1'b1;
            dda_rst_n_q  <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        ST_INIT: begin
          dda_rst_n_q <= 1'b1;
          if (abort || steps == '0) begin
            state_q  <= ST_IDLE;
            dda_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= !abort;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The RUN cycle ending at this edge has executed, even when it is aborted.
          if (step_count_q != '1) step_count_q <= step_count_q + 1'b1;
          if (abort || last_step) begin
            state_q  <= ST_IDLE;
            dda_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= !abort;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          dda_en_q    <= 1'b0;
          dda_rst_n_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ic1        = params[W_IC1];
  assign ic2        = params[W_IC2];
  assign vK_M       = params[W_VKM];
  assign vD_M       = params[W_VDM];
  assign dt         = params[W_DT];
  assign cfg_ok     = cfg_ok_w;
  assign dda_en     = dda_en_q;
  assign dda_rst_n  = dda_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_dda_param_loader.sv
// tb/tb_dda_param_loader.sv - self-checking bench for dda_param_loader
module tb_dda_param_loader;

  localparam int N     = 16;
  localparam int CNT_W = 16;
  localparam int NB    = 12;
  localparam int PH_INIT = 1;
  localparam int PH_RUN  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       byte_in = 8'h00;
  logic             byte_valid = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N-1:0]     ic1, ic2, vK_M, vD_M, dt;
  logic             dda_en, dda_rst_n, cfg_ok, busy, done;
  logic [CNT_W-1:0] step_count;

  dda_param_loader #(.N(N), .ES(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .start      (start),
    .abort      (abort),
    .ic1        (ic1),
    .ic2        (ic2),
    .vK_M       (vK_M),
    .vD_M       (vD_M),
    .dt         (dt),
    .dda_en     (dda_en),
    .dda_rst_n  (dda_rst_n),
    .cfg_ok     (cfg_ok),
    .busy       (busy),
    .done       (done),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: received words, and the remaining run as a queue of phases (front = current cycle).
  logic [15:0] m_w [6];
  int          m_nb;
  bit          m_cfg;
  int          m_sched [$];
  int          m_cnt;
  bit          m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) m_w[i] = 16'h0;
      m_nb = 0; m_cfg = 0; m_cnt = 0; m_done = 0;
      m_sched.delete();
    end else begin
      m_done = 0;
      if (m_sched.size() == 0) begin
        if (byte_valid) begin
          if (m_nb == 0) m_cfg = 0;
          m_w[m_nb / 2] = {m_w[m_nb / 2][7:0], byte_in};
          m_nb++;
          if (m_nb == NB) begin
            m_nb  = 0;
            m_cfg = 1;
          end
        end else if (start && m_cfg && m_nb == 0) begin
          m_cnt = 0;
          m_sched.push_back(PH_INIT);
          for (int i = 0; i < int'(m_w[5]); i++) m_sched.push_back(PH_RUN);
        end
      end else begin
        if (m_sched[0] == PH_RUN) m_cnt++;
        if (abort) m_sched.delete();
        else begin
          void'(m_sched.pop_front());
          if (m_sched.size() == 0) m_done = 1;
        end
      end
    end
  end

  int busy_cyc = 0, en_cyc = 0, rstn_low_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    bit active, in_init;
    active  = (m_sched.size() != 0);
    in_init = active && (m_sched[0] == PH_INIT);
    chk("ic1", ic1, m_w[0]);
    chk("ic2", ic2, m_w[1]);
    chk("vK_M", vK_M, m_w[2]);
    chk("vD_M", vD_M, m_w[3]);
    chk("dt", dt, m_w[4]);
    chk("cfg_ok", cfg_ok, m_cfg);
    chk("busy", busy, active);
    chk("dda_en", dda_en, active);
    chk("dda_rst_n", dda_rst_n, !in_init);
    chk("done", done, m_done);
    chk("step_count", step_count, m_cnt);
    if (busy) busy_cyc++;
    if (dda_en) en_cyc++;
    if (!dda_rst_n) rstn_low_cyc++;
    if (done) done_cyc++;
  end

  task automatic cyc(input bit bv, input logic [7:0] b, input bit st, input bit ab);
    byte_valid = bv; byte_in = b; start = st; abort = ab;
    @(posedge clk);
    #1;
    byte_valid = 0; start = 0; abort = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic load(input logic [95:0] stream, input int first, input int count);
    for (int i = first; i < first + count; i++) cyc(1, stream[95 - 8*i -: 8], 0, 0);
  endtask

  logic [95:0] v5 = 96'h3C00_0000_3800_3000_2000_0005;
  logic [95:0] v0 = 96'h3C00_0000_3800_3000_2000_0000;
  int b0, e0, r0, d0;

  task automatic snap();
    b0 = busy_cyc; e0 = en_cyc; r0 = rstn_low_cyc; d0 = done_cyc;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dda_rst_n", dda_rst_n, 1);
    chk("reset_dda_en", dda_en, 0);
    chk("reset_cfg_ok", cfg_ok, 0);
    chk("reset_busy", busy, 0);
    rst = 0;
    idle(2);

    snap();
    cyc(0, 8'h00, 1, 0);
    idle(3);
    chk("nocfg_busy_cycles", busy_cyc - b0, 0);

    load(v5, 0, 11);
    chk("cfg_ok_before_last", cfg_ok, 0);
    load(v5, 11, 1);
    chk("cfg_ok_after_12", cfg_ok, 1);
    chk("lit_ic1", ic1, 16'h3C00);
    chk("lit_ic2", ic2, 16'h0000);
    chk("lit_vK_M", vK_M, 16'h3800);
    chk("lit_vD_M", vD_M, 16'h3000);
    chk("lit_dt", dt, 16'h2000);

    snap();
    cyc(0, 8'h00, 1, 0);
    chk("init_rst_n_low", dda_rst_n, 0);
    chk("init_en_high", dda_en, 1);
    idle(8);
    chk("run_busy_cycles", busy_cyc - b0, 6);
    chk("run_en_cycles", en_cyc - e0, 6);
    chk("run_rstn_low_cycles", rstn_low_cyc - r0, 1);
    chk("run_done_pulses", done_cyc - d0, 1);
    chk("run_step_count", step_count, 5);

    snap();
    cyc(1, 8'h3C, 1, 0);
    idle(2);
    chk("start_with_byte_busy", busy_cyc - b0, 0);
    chk("start_with_byte_cfg", cfg_ok, 0);
    load(v5, 1, 11);
    chk("reload_cfg_ok", cfg_ok, 1);

    snap();
    cyc(0, 8'h00, 1, 0);
    idle(3);
    cyc(0, 8'h00, 0, 1);
    chk("abort_en", dda_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_step_count", step_count, 3);
    idle(2);
    chk("abort_no_done", done_cyc - d0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("rerun_init_rst_n", dda_rst_n, 0);
    idle(7);
    chk("rerun_step_count", step_count, 5);
    chk("rerun_done_pulses", done_cyc - d0, 1);

    load(v0, 0, 12);
    snap();
    cyc(0, 8'h00, 1, 0);
    chk("steps0_init_rst_n", dda_rst_n, 0);
    idle(3);
    chk("steps0_busy_cycles", busy_cyc - b0, 1);
    chk("steps0_done_pulses", done_cyc - d0, 1);
    chk("steps0_step_count", step_count, 0);

    load(v5, 0, 7);
    chk("partial_cfg_ok", cfg_ok, 0);
    snap();
    cyc(0, 8'h00, 1, 0);
    idle(2);
    chk("partial_start_busy", busy_cyc - b0, 0);
    load(v5, 7, 5);
    chk("partial_done_cfg_ok", cfg_ok, 1);
    cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'hA5, 0, 0);
    idle(4);
    chk("run_bytes_ignored_ic1", ic1, 16'h3C00);
    chk("run_bytes_ignored_cfg", cfg_ok, 1);
    chk("run_bytes_step_count", step_count, 5);

    snap();
    cyc(0, 8'h00, 1, 0);
    idle(3);
    rst = 1;
    #1;
    chk("midrun_reset_en", dda_en, 0);
    chk("midrun_reset_rst_n", dda_rst_n, 1);
    chk("midrun_reset_cfg_ok", cfg_ok, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_step_count", step_count, 0);
    chk("midrun_reset_ic1", ic1, 0);
    @(posedge clk);
    #1;
    rst = 0;
    idle(3);
    chk("midrun_reset_no_done", done_cyc - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
